// File: rtl/timer_entry.sv
// Keypad-side entry buffer and start/pause/cancel sequencer for the MM:SS BCD timer chain.
// Optional feature: define QUICK_START_EN so START on an empty buffer loads 00:30 and cooks.
module timer_entry #(
    parameter int         DONE_CYCLES = 3,
    parameter logic [3:0] KEY_CLEAR   = 4'hA,
    parameter logic [3:0] KEY_START   = 4'hB
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       door_open,
    input  logic       timer_zero,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       load_n,
    output logic       cook_en,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      buf_q, buf_nxt;
    logic [CNT_W-1:0] done_cnt;
    logic             first_run;
    logic             err_nxt;
    logic             key_digit, key_clr, key_go;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_clr   = key_valid && (key_code == KEY_CLEAR);
    assign key_go    = key_valid && (key_code == KEY_START);

    // State, buffer and registered error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_q     <= 16'h0000;
            err       <= 1'b0;
            done_cnt  <= '0;
            first_run <= 1'b0;
        end else begin
            state     <= state_nxt;
            buf_q     <= buf_nxt;
            err       <= err_nxt;
            // Counter restarts from zero on every DONE entry since it idles at zero elsewhere
            done_cnt  <= (state == DONE) ? done_cnt + 1'b1 : '0;
            // Mask timer_zero for the first RUN cycle after a load while the chain settles
            first_run <= (state == LOAD);
        end
    end

    always_comb begin
        state_nxt = state;
        buf_nxt   = buf_q;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (key_digit) begin
                    buf_nxt = {buf_q[11:0], key_code};
                end else if (key_clr) begin
                    buf_nxt = 16'h0000;
                end else if (key_go) begin
                    if (door_open || (buf_q[7:4] > 4'd5)) begin
                        err_nxt = 1'b1;
                    end else if (buf_q == 16'h0000) begin
`ifdef QUICK_START_EN
                        buf_nxt   = 16'h0030;
                        state_nxt = LOAD;
`else
                        err_nxt   = 1'b1;
`endif
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                if (timer_zero && !first_run) begin
                    state_nxt = DONE;
                end else if (door_open) begin
                    state_nxt = PAUSE;
                end else if (key_clr) begin
                    state_nxt = IDLE;
                    buf_nxt   = 16'h0000;
                end
            end
            PAUSE: begin
                if (key_go) begin
                    if (door_open) err_nxt = 1'b1;
                    else           state_nxt = RUN;
                end else if (key_clr) begin
                    state_nxt = IDLE;
                    buf_nxt   = 16'h0000;
                end
            end
            DONE: begin
                if (done_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    buf_nxt   = 16'h0000;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so they change only on clock edges
    always_comb begin
        load_n  = (state != LOAD);
        cook_en = (state == RUN);
        done    = (state == DONE);
    end

    assign min_tens = buf_q[15:12];
    assign min_ones = buf_q[11:8];
    assign sec_tens = buf_q[7:4];
    assign sec_ones = buf_q[3:0];

endmodule

// File: tb/tb_timer_entry.sv
// Directed bench for timer_entry: entry shifting, start/reject, pause/resume, done timing, reset.
module tb_timer_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       door_open;
    logic       timer_zero;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       load_n, cook_en, done, err;

    int n_chk  = 0;
    int n_pass = 0;

    timer_entry dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .door_open (door_open),
        .timer_zero(timer_zero),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .load_n    (load_n),
        .cook_en   (cook_en),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    function automatic logic [15:0] digs();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; door_open = 1'b0; timer_zero = 1'b0;
        tick(); tick();
        chk("rst_digits", digs(), 16'h0000);
        chk("rst_load_n", load_n, 1'b1);
        chk("rst_cook", cook_en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // Entry shifting and clear
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("entry_1234", digs(), 16'h1234);
        press(4'd5);
        chk("entry_roll", digs(), 16'h2345);
        press(4'hA);
        chk("entry_clear", digs(), 16'h0000);

        // Normal cook 01:30, timer_zero asserted early to exercise the settle mask
        press(4'd0); press(4'd1); press(4'd3); press(4'd0);
        chk("entry_0130", digs(), 16'h0130);
        press(4'hB);
        chk("load_low_n1", load_n, 1'b0);
        chk("cook_off_n1", cook_en, 1'b0);
        timer_zero = 1'b1;
        tick();
        chk("load_high_n2", load_n, 1'b1);
        chk("cook_on_n2", cook_en, 1'b1);
        tick();
        chk("tz_masked_cook", cook_en, 1'b1);
        chk("tz_masked_done", done, 1'b0);
        tick();
        chk("done_c1", done, 1'b1);
        chk("done_c1_cook", cook_en, 1'b0);
        tick();
        chk("done_c2", done, 1'b1);
        tick();
        chk("done_c3", done, 1'b1);
        tick();
        chk("done_end", done, 1'b0);
        chk("done_clr_digits", digs(), 16'h0000);
        timer_zero = 1'b0;

        // Rejected starts: bad seconds, then door open
        press(4'd0); press(4'd0); press(4'd7); press(4'd5);
        press(4'hB);
        chk("bad_sec_err", err, 1'b1);
        chk("bad_sec_load", load_n, 1'b1);
        tick();
        chk("bad_sec_err_off", err, 1'b0);
        chk("bad_sec_load2", load_n, 1'b1);
        chk("bad_sec_cook", cook_en, 1'b0);
        press(4'd1);
        chk("bad_sec_idle_shift", digs(), 16'h0751);
        press(4'hA);
        press(4'd0); press(4'd1); press(4'd0); press(4'd0);
        door_open = 1'b1;
        press(4'hB);
        chk("door_err", err, 1'b1);
        chk("door_load", load_n, 1'b1);
        tick();
        chk("door_err_off", err, 1'b0);
        chk("door_load2", load_n, 1'b1);
        door_open = 1'b0;

        // Pause and resume
        press(4'hB);
        chk("p_load", load_n, 1'b0);
        tick();
        chk("p_run", cook_en, 1'b1);
        door_open = 1'b1;
        tick();
        chk("p_paused", cook_en, 1'b0);
        press(4'hB);
        chk("p_open_err", err, 1'b1);
        chk("p_open_cook", cook_en, 1'b0);
        door_open = 1'b0;
        press(4'hB);
        chk("p_resume_cook", cook_en, 1'b1);
        chk("p_resume_noload", load_n, 1'b1);
        chk("p_resume_digits", digs(), 16'h0100);

        // timer_zero beats door_open
        timer_zero = 1'b1; door_open = 1'b1;
        tick();
        chk("prio_done", done, 1'b1);
        chk("prio_cook", cook_en, 1'b0);
        timer_zero = 1'b0; door_open = 1'b0;
        tick(); tick(); tick();
        chk("prio_idle", done, 1'b0);
        chk("prio_digits", digs(), 16'h0000);

        // Digit ignored in RUN, then reset mid-RUN
        press(4'd1); press(4'd2);
        press(4'hB);
        tick();
        press(4'd5);
        chk("run_digit_ign", digs(), 16'h0012);
        chk("run_still_cook", cook_en, 1'b1);
        rst = 1'b1;
        tick();
        chk("mrst_cook", cook_en, 1'b0);
        chk("mrst_load", load_n, 1'b1);
        chk("mrst_digits", digs(), 16'h0000);
        chk("mrst_done", done, 1'b0);
        chk("mrst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // Cancel during RUN
        press(4'd9);
        press(4'hB);
        tick();
        press(4'hA);
        chk("run_clr_cook", cook_en, 1'b0);
        chk("run_clr_digits", digs(), 16'h0000);

        // Empty buffer start
        press(4'hB);
`ifdef QUICK_START_EN
        chk("qs_digits", digs(), 16'h0030);
        chk("qs_load", load_n, 1'b0);
        tick();
        chk("qs_cook", cook_en, 1'b1);
        chk("qs_err", err, 1'b0);
`else
        chk("empty_err", err, 1'b1);
        chk("empty_load", load_n, 1'b1);
        chk("empty_digits", digs(), 16'h0000);
        tick();
        chk("empty_cook", cook_en, 1'b0);
        chk("empty_err_off", err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
